// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and load/store (DM).
// DM has fixed priority; a starvation counter forces an IF grant after
// STARVE_MAX consecutive DM wins while IF waits. One read is outstanding at a
// time with a fixed read latency; writes complete in the issue cycle.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
  localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);
  localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);

  typedef enum logic {IDLE, RD_WAIT} state_t;
  typedef enum logic {OWN_IF, OWN_DM} owner_t;

  state_t            state, state_nxt;
  owner_t            owner, owner_nxt;
  logic [LAT_W-1:0]  lat_cnt, lat_nxt;
  logic [STV_W-1:0]  starve_cnt, starve_nxt;

  logic ret_cyc;
  logic issue_win;
  logic force_if;
  logic grant_dm;
  logic grant_if;
  logic rd_issue;

  // Arbitration: the return cycle of a read doubles as an issue window.
  always_comb begin
    ret_cyc   = (state == RD_WAIT) && (lat_cnt == LAT_ONE);
    issue_win = (state == IDLE) || ret_cyc;
    force_if  = if_req && (starve_cnt == STV_MAX);
    grant_dm  = issue_win && dm_req && !force_if;
    grant_if  = issue_win && if_req && !grant_dm;
    rd_issue  = grant_if || (grant_dm && !dm_we);
  end

  // Next-state: latency countdown, read issue and starvation bookkeeping.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    lat_nxt    = lat_cnt;
    starve_nxt = starve_cnt;

    if (state == RD_WAIT) begin
      if (ret_cyc) begin
        state_nxt = IDLE;
        lat_nxt   = '0;
      end else begin
        lat_nxt = lat_cnt - LAT_ONE;
      end
    end

    if (rd_issue) begin
      state_nxt = RD_WAIT;
      owner_nxt = grant_dm ? OWN_DM : OWN_IF;
      lat_nxt   = LAT_LOAD;
    end

    if (grant_dm && if_req) begin
      if (starve_cnt != STV_MAX) begin
        starve_nxt = starve_cnt + STV_ONE;
      end
    end else if (grant_dm || grant_if) begin
      starve_nxt = '0;
    end
  end

  // Control registers; reset drops any read in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IF;
      lat_cnt    <= '0;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      lat_cnt    <= lat_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  // Output drive: memory port from the winner, read data steered to the owner.
  always_comb begin
    if_ready  = 1'b0;
    dm_ready  = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    if (!rst) begin
      if_ready = grant_if;
      dm_ready = grant_dm;
      busy     = (state == RD_WAIT);
      if (grant_dm) begin
        mem_en    = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end else if (grant_if) begin
        mem_en   = 1'b1;
        mem_addr = if_addr;
      end
      if (ret_cyc) begin
        if (owner == OWN_DM) begin
          dm_rvalid = 1'b1;
          dm_rdata  = mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic, every
// cycle checked against a timeline model (issue/return cycle numbers).
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ready;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ready(dm_ready), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Timeline model: cycle index, earliest issue cycle, pending read return.
  int cyc     = 0;
  int next_ok = 0;
  bit pend_v  = 1'b0;
  bit pend_dm = 1'b0;
  int pend_ret = 0;
  int starve  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check all outputs against the model, advance it.
  task automatic step(input bit r, input bit ireq, input logic [31:0] ia,
                      input bit dreq, input bit dwe, input logic [31:0] da,
                      input logic [31:0] dwd, input logic [31:0] mrd);
    bit win, e_dm, e_if, ret, e_irv, e_drv;
    logic [31:0] e_addr, e_wd, e_ird, e_drd;
    @(negedge clk);
    rst = r; if_req = ireq; if_addr = ia; dm_req = dreq; dm_we = dwe;
    dm_addr = da; dm_wdata = dwd; mem_rdata = mrd;
    #1;
    win   = !r && (cyc >= next_ok);
    e_dm  = win && dreq && !(ireq && starve == STARVE_MAX);
    e_if  = win && ireq && !e_dm;
    ret   = !r && pend_v && (cyc == pend_ret);
    e_irv = ret && !pend_dm;
    e_drv = ret && pend_dm;
    e_addr = e_dm ? da : (e_if ? ia : 32'h0);
    e_wd   = e_dm ? dwd : 32'h0;
    e_ird  = e_irv ? mrd : 32'h0;
    e_drd  = e_drv ? mrd : 32'h0;
    chk("if_ready",  if_ready,  e_if);
    chk("dm_ready",  dm_ready,  e_dm);
    chk("mem_en",    mem_en,    e_dm || e_if);
    chk("mem_we",    mem_we,    e_dm && dwe);
    chk("mem_addr",  mem_addr,  e_addr);
    chk("mem_wdata", mem_wdata, e_wd);
    chk("if_rvalid", if_rvalid, e_irv);
    chk("dm_rvalid", dm_rvalid, e_drv);
    chk("if_rdata",  if_rdata,  e_ird);
    chk("dm_rdata",  dm_rdata,  e_drd);
    chk("busy",      busy,      !r && pend_v);
    if (r) begin
      pend_v  = 1'b0;
      starve  = 0;
      next_ok = cyc + 1;
    end else begin
      if (ret) pend_v = 1'b0;
      if (e_if || (e_dm && !dwe)) begin
        pend_v   = 1'b1;
        pend_dm  = e_dm;
        pend_ret = cyc + MEM_LAT;
        next_ok  = cyc + MEM_LAT;
      end
      if (e_dm && ireq) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
      else if (e_dm || e_if) starve = 0;
    end
    cyc++;
  endtask

  task automatic idle(input logic [31:0] mrd);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, mrd);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;

    // Reset with requests asserted: everything must stay 0.
    step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1, 32'h80, 32'h1234, 32'hFFFF);
    chk("rst_mem_en", mem_en, 1'b0);

    // Single fetch.
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("fetch_ready", if_ready, 1'b1);
    chk("fetch_addr", mem_addr, 32'h40);
    idle(32'h0);
    chk("fetch_busy1", busy, 1'b1);
    idle(32'h13);
    chk("fetch_rvalid", if_rvalid, 1'b1);
    chk("fetch_rdata", if_rdata, 32'h13);
    chk("fetch_busy2", busy, 1'b1);
    idle(32'h0);

    // Simultaneous requests: DM first, IF at the return cycle.
    step(1'b0, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, 32'h0);
    chk("simul_dm", dm_ready, 1'b1);
    chk("simul_if_wait", if_ready, 1'b0);
    step(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 32'hAAAA5555);
    chk("simul_dm_rvalid", dm_rvalid, 1'b1);
    chk("simul_if_grant", if_ready, 1'b1);
    idle(32'h0);
    idle(32'h00000093);
    chk("simul_if_rvalid", if_rvalid, 1'b1);

    // Store then fetch.
    step(1'b0, 1'b1, 32'h48, 1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h0);
    chk("store_we", mem_we, 1'b1);
    chk("store_wdata", mem_wdata, 32'hDEADBEEF);
    step(1'b0, 1'b1, 32'h48, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    chk("store_no_rvalid", dm_rvalid, 1'b0);
    chk("store_then_fetch", if_ready, 1'b1);
    idle(32'h0);
    idle(32'h0);

    // Starvation guard with both requesters held.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 1'b1, 32'h50, 1'b1, 1'b0, 32'h300 + i, 32'h0, $urandom);
      if (i == 0 || i == 2 || i == 4 || i == 6 || i == 10) chk("starve_dm", dm_ready, 1'b1);
      if (i == 8) chk("starve_if", if_ready, 1'b1);
    end
    idle(32'h0);
    idle(32'h0);

    // Reset mid-read: read dropped, regrant right after.
    step(1'b0, 1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    do_reset();
    chk("rst_busy", busy, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h400, 32'h0, 32'h77);
    chk("rst_no_rvalid", if_rvalid, 1'b0);
    chk("rst_regrant", dm_ready, 1'b1);

    // Zero-hold DM pulse outside the issue window.
    idle(32'h0);
    step(1'b0, 1'b1, 32'h64, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h500, 32'h0, 32'h0);
    chk("pulse_no_ready", dm_ready, 1'b0);
    chk("pulse_no_en", mem_en, 1'b0);
    idle(32'h0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1), $urandom,
           $urandom_range(0, 1), $urandom_range(0, 1), $urandom, $urandom, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
